cpu_controller: RTL and testbench

- Moore FSM that generates every control input of the 16-bit register/ALU datapath: register-file selects, A/B/C/status load enables, operand muxes, write-back mux.
- Also drives the program counter, instruction register and memory command.
- Sits between the instruction decoder (supplies opcode/op) and the datapath plus memory interface.
- Executes one instruction at a time over multiple cycles: fetch, decode, execute, write-back.

---
 rtl/cpu_ctrl_pkg.sv | 106 ++++++++++
 rtl/cpu_controller.sv | 100 ++++++++++
 tb/tb_cpu_controller.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/cpu_ctrl_pkg.sv
// rtl/cpu_ctrl_pkg.sv - state encodings, control constants and per-state output decode
package cpu_ctrl_pkg;

    localparam int STATE_W = 5;

    typedef enum logic [STATE_W-1:0] {
        S_RST   = 5'd0,
        S_IF1   = 5'd1,
        S_IF2   = 5'd2,
        S_UPC   = 5'd3,
        S_DEC   = 5'd4,
        S_WIMM  = 5'd5,
        S_GETA  = 5'd6,
        S_GETB  = 5'd7,
        S_EXEC  = 5'd8,
        S_WREG  = 5'd9,
        S_ADDR  = 5'd10,
        S_LADDR = 5'd11,
        S_RD1   = 5'd12,
        S_RD2   = 5'd13,
        S_GETD  = 5'd14,
        S_PASS  = 5'd15,
        S_WR    = 5'd16,
        S_HALT  = 5'd17
    } state_t;

    localparam logic [1:0] MEM_NONE  = 2'b00;
    localparam logic [1:0] MEM_READ  = 2'b01;
    localparam logic [1:0] MEM_WRITE = 2'b10;

    localparam logic [2:0] NSEL_NONE = 3'b000;
    localparam logic [2:0] NSEL_RN   = 3'b001;
    localparam logic [2:0] NSEL_RD   = 3'b010;
    localparam logic [2:0] NSEL_RM   = 3'b100;

    localparam logic [3:0] VSEL_NONE  = 4'b0000;
    localparam logic [3:0] VSEL_C     = 4'b0001;
    localparam logic [3:0] VSEL_IMM   = 4'b0010;
    localparam logic [3:0] VSEL_MDATA = 4'b0100;
    localparam logic [3:0] VSEL_PC    = 4'b1000;

    localparam logic [2:0] OPC_LDR  = 3'b011;
    localparam logic [2:0] OPC_STR  = 3'b100;
    localparam logic [2:0] OPC_ALU  = 3'b101;
    localparam logic [2:0] OPC_MOV  = 3'b110;
    localparam logic [2:0] OPC_HALT = 3'b111;

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_CMP  = 2'b01;
    localparam logic [1:0] OP_AND  = 2'b10;
    localparam logic [1:0] OP_MVN  = 2'b11;
    localparam logic [1:0] OP_MOVR = 2'b00;
    localparam logic [1:0] OP_MOVI = 2'b10;

    typedef struct packed {
        logic [2:0] nsel;
        logic [3:0] vsel;
        logic       loada;
        logic       loadb;
        logic       loadc;
        logic       loads;
        logic       asel;
        logic       bsel;
        logic       write;
        logic       load_ir;
        logic       load_pc;
        logic       reset_pc;
        logic       addr_sel;
        logic       load_addr;
        logic [1:0] mem_cmd;
        logic       halted;
    } ctrl_t;

    // EXEC is the only state whose outputs depend on the held instruction.
    function automatic ctrl_t ctrl_for(state_t s, logic zero_a, logic is_cmp);
        ctrl_t c;
        c = '0;
        case (s)
            S_RST:   begin c.reset_pc = 1'b1; c.load_pc = 1'b1; end
            S_IF1:   begin c.addr_sel = 1'b1; c.mem_cmd = MEM_READ; end
            S_IF2:   begin c.addr_sel = 1'b1; c.mem_cmd = MEM_READ; c.load_ir = 1'b1; end
            S_UPC:   c.load_pc = 1'b1;
            S_WIMM:  begin c.nsel = NSEL_RN; c.vsel = VSEL_IMM; c.write = 1'b1; end
            S_GETA:  begin c.nsel = NSEL_RN; c.loada = 1'b1; end
            S_GETB:  begin c.nsel = NSEL_RM; c.loadb = 1'b1; end
            S_EXEC:  begin c.loadc = 1'b1; c.asel = zero_a; c.loads = is_cmp; end
            S_WREG:  begin c.nsel = NSEL_RD; c.vsel = VSEL_C; c.write = 1'b1; end
            S_ADDR:  begin c.bsel = 1'b1; c.loadc = 1'b1; end
            S_LADDR: c.load_addr = 1'b1;
            S_RD1:   c.mem_cmd = MEM_READ;
            S_RD2:   begin
                c.mem_cmd = MEM_READ;
                c.nsel    = NSEL_RD;
                c.vsel    = VSEL_MDATA;
                c.write   = 1'b1;
            end
            S_GETD:  begin c.nsel = NSEL_RD; c.loadb = 1'b1; end
            S_PASS:  begin c.asel = 1'b1; c.loadc = 1'b1; end
            S_WR:    c.mem_cmd = MEM_WRITE;
            S_HALT:  c.halted = 1'b1;
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/cpu_controller.sv
// rtl/cpu_controller.sv - multi-cycle Moore control FSM for the 16-bit register/ALU datapath
module cpu_controller
    import cpu_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic [2:0] opcode,
    input  logic [1:0] op,
    output logic [2:0] nsel,
    output logic [3:0] vsel,
    output logic       loada,
    output logic       loadb,
    output logic       loadc,
    output logic       loads,
    output logic       asel,
    output logic       bsel,
    output logic       write,
    output logic       load_ir,
    output logic       load_pc,
    output logic       reset_pc,
    output logic       addr_sel,
    output logic       load_addr,
    output logic [1:0] mem_cmd,
    output logic       halted
);

    state_t state_q, state_d;
    ctrl_t  ctrl_q;

    logic is_ldr, is_mem, is_cmp, zero_a;

    assign is_ldr = (opcode == OPC_LDR) && (op == 2'b00);
    assign is_mem = is_ldr || ((opcode == OPC_STR) && (op == 2'b00));
    assign is_cmp = (opcode == OPC_ALU) && (op == OP_CMP);
    assign zero_a = ((opcode == OPC_MOV) && (op == OP_MOVR)) ||
                    ((opcode == OPC_ALU) && (op == OP_MVN));

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RST:   state_d = S_IF1;
            S_IF1:   state_d = S_IF2;
            S_IF2:   state_d = S_UPC;
            S_UPC:   state_d = S_DEC;
            S_DEC: begin
                case ({opcode, op})
                    {OPC_MOV, OP_MOVI}:                     state_d = S_WIMM;
                    {OPC_MOV, OP_MOVR}, {OPC_ALU, OP_MVN}:  state_d = S_GETB;
                    {OPC_ALU, OP_ADD}, {OPC_ALU, OP_CMP},
                    {OPC_ALU, OP_AND}, {OPC_LDR, 2'b00},
                    {OPC_STR, 2'b00}:                       state_d = S_GETA;
                    default:                                state_d = S_HALT;
                endcase
            end
            S_WIMM:  state_d = S_IF1;
            S_GETA:  state_d = is_mem ? S_ADDR : S_GETB;
            S_GETB:  state_d = S_EXEC;
            S_EXEC:  state_d = is_cmp ? S_IF1 : S_WREG;
            S_WREG:  state_d = S_IF1;
            S_ADDR:  state_d = S_LADDR;
            S_LADDR: state_d = is_ldr ? S_RD1 : S_GETD;
            S_RD1:   state_d = S_RD2;
            S_RD2:   state_d = S_IF1;
            S_GETD:  state_d = S_PASS;
            S_PASS:  state_d = S_WR;
            S_WR:    state_d = S_IF1;
            S_HALT:  state_d = S_HALT;
            default: state_d = S_RST;
        endcase
    end

    // Outputs are decoded from the next state so they change together with state_q.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_RST;
            ctrl_q  <= ctrl_for(S_RST, 1'b0, 1'b0);
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_for(state_d, zero_a, is_cmp);
        end
    end

    assign nsel      = ctrl_q.nsel;
    assign vsel      = ctrl_q.vsel;
    assign loada     = ctrl_q.loada;
    assign loadb     = ctrl_q.loadb;
    assign loadc     = ctrl_q.loadc;
    assign loads     = ctrl_q.loads;
    assign asel      = ctrl_q.asel;
    assign bsel      = ctrl_q.bsel;
    assign write     = ctrl_q.write;
    assign load_ir   = ctrl_q.load_ir;
    assign load_pc   = ctrl_q.load_pc;
    assign reset_pc  = ctrl_q.reset_pc;
    assign addr_sel  = ctrl_q.addr_sel;
    assign load_addr = ctrl_q.load_addr;
    assign mem_cmd   = ctrl_q.mem_cmd;
    assign halted    = ctrl_q.halted;

endmodule

// File: tb/tb_cpu_controller.sv
// tb/tb_cpu_controller.sv - self-checking bench for cpu_controller
module tb_cpu_controller;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [2:0] opcode;
    logic [1:0] op;
    logic [2:0] nsel;
    logic [3:0] vsel;
    logic       loada, loadb, loadc, loads, asel, bsel, write;
    logic       load_ir, load_pc, reset_pc, addr_sel, load_addr, halted;
    logic [1:0] mem_cmd;

    always #5 clk = ~clk;

    cpu_controller dut (
        .clk(clk), .reset_n(reset_n), .opcode(opcode), .op(op),
        .nsel(nsel), .vsel(vsel), .loada(loada), .loadb(loadb), .loadc(loadc),
        .loads(loads), .asel(asel), .bsel(bsel), .write(write), .load_ir(load_ir),
        .load_pc(load_pc), .reset_pc(reset_pc), .addr_sel(addr_sel),
        .load_addr(load_addr), .mem_cmd(mem_cmd), .halted(halted)
    );

    typedef struct packed {
        logic [2:0] nsel;
        logic [3:0] vsel;
        logic       loada, loadb, loadc, loads, asel, bsel, write;
        logic       load_ir, load_pc, reset_pc, addr_sel, load_addr;
        logic [1:0] mem_cmd;
        logic       halted;
    } ev_t;

    ev_t act;
    assign act = {nsel, vsel, loada, loadb, loadc, loads, asel, bsel, write,
                  load_ir, load_pc, reset_pc, addr_sel, load_addr, mem_cmd, halted};

    ev_t exp_q[$];
    ev_t seq[$];
    ev_t cur;
    int  n_cmp = 0;
    int  n_bad = 0;
    int  cyc   = 0;

    function automatic ev_t z();
        ev_t e;
        e = '0;
        return e;
    endfunction

    function automatic void rd_reg(input logic to_a, input logic [2:0] n);
        ev_t e;
        e = z(); e.nsel = n;
        if (to_a) e.loada = 1'b1; else e.loadb = 1'b1;
        seq.push_back(e);
    endfunction

    function automatic void alu(input logic a0, input logic b_imm, input logic flags);
        ev_t e;
        e = z(); e.loadc = 1'b1; e.asel = a0; e.bsel = b_imm; e.loads = flags;
        seq.push_back(e);
    endfunction

    function automatic void wb(input logic [2:0] n, input logic [3:0] v);
        ev_t e;
        e = z(); e.write = 1'b1; e.nsel = n; e.vsel = v;
        seq.push_back(e);
    endfunction

    // Expected cycle-by-cycle control stream for one instruction, starting at fetch.
    function automatic void build(input logic [2:0] opc, input logic [1:0] o);
        ev_t e;
        seq.delete();
        e = z(); e.addr_sel = 1'b1; e.mem_cmd = 2'b01; seq.push_back(e);
        e.load_ir = 1'b1; seq.push_back(e);
        e = z(); e.load_pc = 1'b1; seq.push_back(e);
        seq.push_back(z());
        case ({opc, o})
            5'b110_10: wb(3'b001, 4'b0010);
            5'b110_00, 5'b101_11: begin
                rd_reg(1'b0, 3'b100); alu(1'b1, 1'b0, 1'b0); wb(3'b010, 4'b0001);
            end
            5'b101_00, 5'b101_10: begin
                rd_reg(1'b1, 3'b001); rd_reg(1'b0, 3'b100);
                alu(1'b0, 1'b0, 1'b0); wb(3'b010, 4'b0001);
            end
            5'b101_01: begin
                rd_reg(1'b1, 3'b001); rd_reg(1'b0, 3'b100); alu(1'b0, 1'b0, 1'b1);
            end
            5'b011_00: begin
                rd_reg(1'b1, 3'b001); alu(1'b0, 1'b1, 1'b0);
                e = z(); e.load_addr = 1'b1; seq.push_back(e);
                e = z(); e.mem_cmd = 2'b01; seq.push_back(e);
                e.write = 1'b1; e.nsel = 3'b010; e.vsel = 4'b0100; seq.push_back(e);
            end
            5'b100_00: begin
                rd_reg(1'b1, 3'b001); alu(1'b0, 1'b1, 1'b0);
                e = z(); e.load_addr = 1'b1; seq.push_back(e);
                rd_reg(1'b0, 3'b010); alu(1'b1, 1'b0, 1'b0);
                e = z(); e.mem_cmd = 2'b10; seq.push_back(e);
            end
            default: begin
                for (int i = 0; i < 20; i++) begin
                    e = z(); e.halted = 1'b1; seq.push_back(e);
                end
            end
        endcase
    endfunction

    function automatic ev_t rst_vec();
        ev_t e;
        e = z(); e.reset_pc = 1'b1; e.load_pc = 1'b1;
        return e;
    endfunction

    task automatic check_int(input string name, input int actual, input int required);
        n_cmp++;
        if (actual != required) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, required);
        end
    endtask

    always @(negedge clk) begin
        cyc++;
        if (exp_q.size() > 0) begin
            cur = exp_q.pop_front();
            n_cmp++;
            if (act !== cur) begin
                n_bad++;
                $display("FAIL ctrl cyc=%0d op=%b_%b got=%b expected=%b", cyc, opcode, op, act, cur);
            end
            n_cmp++;
            if ((act.write && act.mem_cmd == 2'b10) ||
                ((act.write || act.loada || act.loadb) && !$onehot(act.nsel)) ||
                (act.write && !$onehot(act.vsel))) begin
                n_bad++;
                $display("FAIL invariant cyc=%0d got=%b expected write/nsel/vsel consistent", cyc, act);
            end
        end
    end

    task automatic run_instr(input logic [2:0] opc, input logic [1:0] o, input int k);
        int n;
        #1;
        build(opc, o);
        n = (k == 0) ? seq.size() : k;
        for (int i = 0; i < n; i++) exp_q.push_back(seq[i]);
        @(negedge clk);
        #1;
        opcode = opc;
        op     = o;
        repeat (n - 1) @(negedge clk);
    endtask

    task automatic do_reset(input int c);
        #1;
        reset_n = 1'b0;
        for (int i = 0; i < c; i++) exp_q.push_back(rst_vec());
        repeat (c) @(negedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0;
        opcode  = 3'b000;
        op      = 2'b00;

        build(3'b110, 2'b10); check_int("len_movi", seq.size(), 5);
        build(3'b110, 2'b00); check_int("len_movr", seq.size(), 7);
        build(3'b101, 2'b00); check_int("len_add",  seq.size(), 8);
        build(3'b101, 2'b01); check_int("len_cmp",  seq.size(), 7);
        build(3'b011, 2'b00); check_int("len_ldr",  seq.size(), 9);
        check_int("ldr_vsel", int'(seq[8].vsel), 4);
        build(3'b100, 2'b00); check_int("len_str",  seq.size(), 10);
        check_int("str_wr_cmd", int'(seq[9].mem_cmd), 2);

        do_reset(3);
        run_instr(3'b110, 2'b10, 0);
        run_instr(3'b110, 2'b00, 0);
        run_instr(3'b101, 2'b11, 0);
        run_instr(3'b101, 2'b00, 0);
        run_instr(3'b101, 2'b10, 0);
        run_instr(3'b101, 2'b01, 0);
        run_instr(3'b011, 2'b00, 0);
        run_instr(3'b100, 2'b00, 0);
        run_instr(3'b110, 2'b10, 0);

        run_instr(3'b111, 2'b01, 0);
        do_reset(2);
        run_instr(3'b000, 2'b00, 0);
        do_reset(2);
        run_instr(3'b011, 2'b00, 8);
        do_reset(2);
        run_instr(3'b110, 2'b10, 0);

        @(negedge clk);
        #1;
        check_int("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
